// File: rtl/acq_search_scheduler.sv
// Acquisition search scheduler: sweeps code phase x Doppler zig-zag over two satellites.
// Optional macro ACQ_VERIFY_EN adds a CONFIRM state requiring CONFIRM_N extra hits before lock.
module acq_search_scheduler #(
    parameter int unsigned CODE_POS  = 2046,
    parameter int unsigned NCO_W     = 30,
    parameter int unsigned BIN_W     = 6,
    parameter int unsigned CONFIRM_N = 3
) (
    input  logic             mclk,
    input  logic             mclr,
    input  logic             start,
    input  logic             abort,
    input  logic             dwell_done,
    input  logic             acq_hit,
    input  logic             loss_of_lock,
    input  logic [4:0]       sat_id1,
    input  logic [4:0]       sat_id2,
    input  logic [NCO_W-1:0] doppler_step,
    input  logic [BIN_W-1:0] doppler_bins,
    output logic             code_slip,
    output logic [NCO_W-1:0] carr_offset,
    output logic [4:0]       sat_id,
    output logic [10:0]      code_pos,
    output logic             search_busy,
    output logic             acq_lock,
    output logic             search_fail
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StDwell   = 3'd1;
    localparam logic [2:0] StConfirm = 3'd2;
    localparam logic [2:0] StLocked  = 3'd3;
    localparam logic [2:0] StFail    = 3'd4;

    localparam logic [10:0] LastPos = 11'(CODE_POS - 1);

    if (CONFIRM_N < 1) begin : g_bad_confirm_n
        $error("CONFIRM_N must be at least 1");
    end

    logic [2:0]       state_q, state_d;
    logic [10:0]      code_pos_q, code_pos_d;
    logic [BIN_W:0]   bin_q, bin_d;
    logic [NCO_W-1:0] carr_q, carr_d;
    logic [4:0]       sat_q, sat_d;
    logic             second_q, second_d;
    logic             slip_q, slip_d;
    logic             busy_q, lock_q, fail_q;
    logic             do_miss;
    logic [BIN_W:0]   last_bin;
    logic [NCO_W-1:0] zz_next;

`ifdef ACQ_VERIFY_EN
    localparam int unsigned ConfW = $clog2(CONFIRM_N + 1);
    logic [ConfW-1:0] conf_q, conf_d;
`endif

    assign last_bin = {doppler_bins, 1'b0};
    // Non-positive offsets step outward on the positive side; positive ones mirror.
    assign zz_next = (carr_q[NCO_W-1] || carr_q == '0) ? doppler_step - carr_q : '0 - carr_q;

    always_comb begin
        state_d    = state_q;
        code_pos_d = code_pos_q;
        bin_d      = bin_q;
        carr_d     = carr_q;
        sat_d      = sat_q;
        second_d   = second_q;
        slip_d     = 1'b0;
        do_miss    = 1'b0;
`ifdef ACQ_VERIFY_EN
        conf_d     = conf_q;
`endif
        case (state_q)
            StIdle, StFail: begin
                if (start) begin
                    state_d    = StDwell;
                    code_pos_d = '0;
                    bin_d      = '0;
                    carr_d     = '0;
                    sat_d      = sat_id1;
                    second_d   = 1'b0;
                end
            end
            StDwell: begin
                if (dwell_done) begin
                    if (acq_hit) begin
`ifdef ACQ_VERIFY_EN
                        state_d = StConfirm;
                        conf_d  = '0;
`else
                        state_d = StLocked;
`endif
                    end else begin
                        do_miss = 1'b1;
                    end
                end
            end
`ifdef ACQ_VERIFY_EN
            StConfirm: begin
                if (dwell_done) begin
                    if (!acq_hit) begin
                        do_miss = 1'b1;
                    end else if (conf_q == ConfW'(CONFIRM_N - 1)) begin
                        state_d = StLocked;
                    end else begin
                        conf_d = conf_q + 1'b1;
                    end
                end
            end
`endif
            StLocked: begin
                if (loss_of_lock) begin
                    state_d    = StDwell;
                    code_pos_d = '0;
                    bin_d      = '0;
                    carr_d     = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_miss) begin
            state_d = StDwell;
            if (code_pos_q < LastPos) begin
                code_pos_d = code_pos_q + 11'd1;
                slip_d     = 1'b1;
            end else if (bin_q < last_bin) begin
                code_pos_d = '0;
                bin_d      = bin_q + 1'b1;
                carr_d     = zz_next;
            end else if (!second_q) begin
                sat_d      = sat_id2;
                second_d   = 1'b1;
                code_pos_d = '0;
                bin_d      = '0;
                carr_d     = '0;
            end else begin
                state_d = StFail;
            end
        end

        if (abort) begin
            state_d    = StIdle;
            code_pos_d = '0;
            bin_d      = '0;
            carr_d     = '0;
            sat_d      = '0;
            second_d   = 1'b0;
            slip_d     = 1'b0;
        end
    end

    always_ff @(posedge mclk or posedge mclr) begin
        if (mclr) begin
            state_q    <= StIdle;
            code_pos_q <= '0;
            bin_q      <= '0;
            carr_q     <= '0;
            sat_q      <= '0;
            second_q   <= 1'b0;
            slip_q     <= 1'b0;
            busy_q     <= 1'b0;
            lock_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_pos_q <= code_pos_d;
            bin_q      <= bin_d;
            carr_q     <= carr_d;
            sat_q      <= sat_d;
            second_q   <= second_d;
            slip_q     <= slip_d;
            busy_q     <= (state_d == StDwell) || (state_d == StConfirm);
            lock_q     <= (state_d == StLocked);
            fail_q     <= (state_d == StFail);
        end
    end

`ifdef ACQ_VERIFY_EN
    always_ff @(posedge mclk or posedge mclr) begin
        if (mclr) begin
            conf_q <= '0;
        end else begin
            conf_q <= conf_d;
        end
    end
`endif

    assign code_slip   = slip_q;
    assign carr_offset = carr_q;
    assign sat_id      = sat_q;
    assign code_pos    = code_pos_q;
    assign search_busy = busy_q;
    assign acq_lock    = lock_q;
    assign search_fail = fail_q;

endmodule

// File: doc/acq_search_scheduler.md
ACQ_SEARCH_SCHEDULER -- requirements
Module: acq_search_scheduler

Interface
REQ-001 Parameter CODE_POS, default 2046, half-chip code positions per Doppler bin.
REQ-002 Parameter NCO_W, default 30, carrier offset word width.
REQ-003 Parameter BIN_W, default 6, Doppler bin count width.
REQ-004 Parameter CONFIRM_N, default 3, confirmation dwells; used only under ACQ_VERIFY_EN.
REQ-005 Port: mclk, in, 1, the block's single clock; all logic SHALL be on its rising edge.
REQ-006 Port: mclr, in, 1, asynchronous active-high reset.
REQ-007 Port: start, in, 1, one-cycle search start request.
REQ-008 Port: abort, in, 1, one-cycle abort request.
REQ-009 Port: dwell_done, in, 1, one-cycle pulse at end of each integration dwell.
REQ-010 Port: acq_hit, in, 1, threshold result, valid only while dwell_done=1.
REQ-011 Port: loss_of_lock, in, 1, level from tracking loop.
REQ-012 Port: sat_id1 / sat_id2, in, 5 each, first and second satellite PRN.
REQ-013 Port: doppler_step, in, NCO_W, carrier offset increment per bin.
REQ-014 Port: doppler_bins, in, BIN_W, bins searched on each side of zero.
REQ-015 Port: code_slip, out, 1, one-cycle request to advance code by one half-chip.
REQ-016 Port: carr_offset, out, NCO_W, two's-complement carrier offset word.
REQ-017 Port: sat_id, out, 5, PRN currently searched.
REQ-018 Port: code_pos, out, 11, current code position index.
REQ-019 Port: search_busy / acq_lock / search_fail, out, 1 each, status levels.

Function
REQ-020 States SHALL be IDLE, DWELL, CONFIRM, LOCKED, FAIL; all outputs registered.
REQ-021 IDLE + start -> DWELL with code_pos=0, bin index j=0, carr_offset=0, sat_id=sat_id1; start outside IDLE/FAIL SHALL be ignored.
REQ-022 DWELL + dwell_done + acq_hit -> LOCKED (CONFIRM under ACQ_VERIFY_EN), code_pos and carr_offset held.
REQ-023 DWELL + dwell_done + !acq_hit, code_pos<CODE_POS-1 -> code_pos+1 and code_slip=1 for exactly the next cycle.
REQ-024 Miss at code_pos=CODE_POS-1 -> code_pos=0, j+1, carr_offset=next zig-zag value; no code_slip.
REQ-025 Zig-zag: if carr_offset<=0 (signed) next = -carr_offset+doppler_step, else next = -carr_offset, modulo 2^NCO_W; sequence 0,+s,-s,+2s,-2s,...
REQ-026 Miss at last position of j=2*doppler_bins -> if on sat_id1, switch to sat_id2 with code_pos=0, j=0, carr_offset=0; if on sat_id2 -> FAIL.
REQ-027 doppler_bins=0 SHALL search only the zero-offset bin per satellite.
REQ-028 LOCKED: acq_lock=1; loss_of_lock=1 -> DWELL on current satellite with code_pos=0, j=0, carr_offset=0.
REQ-029 FAIL: search_fail=1 until start (restarts per REQ-021) or abort.
REQ-030 abort in any state -> IDLE with all outputs at reset values; abort wins over simultaneous dwell_done or start.
REQ-031 search_busy=1 exactly in DWELL and CONFIRM.
REQ-032 sat_id1/sat_id2 SHALL be sampled at satellite selection; later changes SHALL NOT affect sat_id until the next selection.
REQ-033 dwell_done outside DWELL/CONFIRM SHALL be ignored.

Reset
REQ-034 mclr=1 SHALL asynchronously force IDLE, code_slip=0, carr_offset=0, sat_id=0, code_pos=0, search_busy=0, acq_lock=0, search_fail=0.
REQ-035 Reset mid-search SHALL discard all search progress; first start afterward begins at sat_id1, bin 0.

Configuration
REQ-036 Macro ACQ_VERIFY_EN defined: hit enters CONFIRM; CONFIRM_N consecutive hits -> LOCKED; any miss -> treated as DWELL miss at held position (REQ-023..026).
REQ-037 Macro ACQ_VERIFY_EN undefined: CONFIRM state and its counter SHALL not exist; first hit -> LOCKED.

Verification
REQ-038 CODE_POS=4, doppler_bins=1, step=100, all misses -> code_slip 3 per bin, carr_offset 0,+100,-100 on sat_id1 then sat_id2, then search_fail=1 after 24 dwells.
REQ-039 Hit on dwell 6 (CODE_POS=4) -> acq_lock=1, code_pos=1, carr_offset=+100, no code_slip that cycle.
REQ-040 abort and dwell_done same cycle in DWELL -> IDLE, all outputs zero, no code_slip.
REQ-041 mclr asserted mid-DWELL asynchronously -> outputs zero before next mclk edge; start -> sat_id=sat_id1, carr_offset=0.
REQ-042 ACQ_VERIFY_EN, CONFIRM_N=3, hit then hit,miss -> no lock, code_pos+1 with code_slip; hit,hit,hit,hit -> acq_lock=1.
REQ-043 LOCKED then loss_of_lock=1 -> DWELL, search_busy=1, code_pos=0, carr_offset=0, same sat_id.
